slot_arbiter: RTL and testbench

//   Round-robin time-slice arbiter that shares one mod-SLOT_LEN slot counter among NREQ requesters.
//   - The slot counter runs 0..SLOT_LEN-1 while a grant is held.
//   - A grant lasts one full count sequence, or less on early release.
//   - Sits between the requesting sequential blocks and the shared counter resource.
//   - Drives the one-hot grant bus and exposes the live slot count.

---
 rtl/arb_pkg.sv | 28 ++
 rtl/slot_counter.sv | 38 +++
 rtl/slot_arbiter.sv | 109 ++++++++++
 tb/tb_slot_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and the round-robin search used by slot_arbiter.
package arb_pkg;

   localparam int unsigned MAX_REQ = 8;
   localparam int unsigned PICK_W  = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // Returns {hit, index}: first set req bit scanning ptr, ptr+1, .. modulo nreq.
   function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int unsigned        nreq);
      logic [PICK_W-1:0] res;
      int unsigned       idx;
      res = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         idx = (32'(ptr) + i) % nreq;
         if (!res[PICK_W-1] && (i < nreq) && req[3'(idx)]) begin
            res = {1'b1, 3'(idx)};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/slot_counter.sv
// Mod-SLOT_LEN tick counter; clr has priority over en.
module slot_counter #(
   parameter int unsigned SLOT_LEN = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   output logic [2:0] cnt,
   output logic       last
);

   localparam logic [2:0] CNT_MAX = 3'(SLOT_LEN - 1);

   logic [2:0] cnt_q;
   logic [2:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 3'd0;
      end else if (en) begin
         cnt_d = (cnt_q == CNT_MAX) ? 3'd0 : cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 3'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == CNT_MAX);

endmodule

// File: rtl/slot_arbiter.sv
// Round-robin time-slice arbiter: one grantee at a time owns the shared slot counter.
module slot_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned SLOT_LEN = 5,
   parameter int unsigned IDW      = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] done,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id,
   output logic [2:0]      slot_cnt,
   output logic            slot_last,
   output logic            busy
);

   arb_state_e        state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [IDW-1:0]    grant_id_q, grant_id_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    nxt_ptr;
   logic [PICK_W-1:0] pick;
   logic              slot_end;
   logic              cnt_clr;
   logic              cnt_en;
   logic              cnt_last;
   logic [2:0]        cnt;

   slot_counter #(
      .SLOT_LEN(SLOT_LEN)
   ) u_slot_counter (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt),
      .last(cnt_last)
   );

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      ptr_d      = ptr_q;
      nxt_ptr    = ptr_q;
      pick       = '0;
      slot_end   = 1'b0;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            pick    = rr_pick(8'(req), 3'(ptr_q), NREQ);
            if (pick[PICK_W-1]) begin
               state_d    = ST_GRANT;
               grant_id_d = IDW'(pick[2:0]);
               grant_d    = NREQ'(1) << pick[2:0];
            end
         end
         ST_GRANT: begin
            // Only the grantee's own req/done bits can end its slot.
            slot_end = cnt_last || done[grant_id_q] || !req[grant_id_q];
            if (slot_end) begin
               cnt_clr = 1'b1;
               nxt_ptr = IDW'((32'(grant_id_q) + 32'd1) % NREQ);
               ptr_d   = nxt_ptr;
               pick    = rr_pick(8'(req), 3'(nxt_ptr), NREQ);
               if (pick[PICK_W-1]) begin
                  grant_id_d = IDW'(pick[2:0]);
                  grant_d    = NREQ'(1) << pick[2:0];
               end else begin
                  state_d    = ST_IDLE;
                  grant_id_d = '0;
                  grant_d    = '0;
               end
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         grant_id_q <= '0;
         ptr_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         ptr_q      <= ptr_d;
      end
   end

   assign grant     = grant_q;
   assign grant_id  = grant_id_q;
   assign slot_cnt  = cnt;
   assign busy      = (state_q == ST_GRANT);
   assign slot_last = busy && cnt_last;

endmodule

// File: tb/tb_slot_arbiter.sv
// Self-checking bench for slot_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_slot_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned L   = 5;
   localparam int unsigned IDW = 2;
   localparam int unsigned VW  = N + IDW + 5;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   done;
   logic [N-1:0]   grant;
   logic [IDW-1:0] grant_id;
   logic [2:0]     slot_cnt;
   logic           slot_last;
   logic           busy;

   int checks;
   int errors;

   // Reference model state: who owns the counter, how long they have held it, and the rotation start.
   int m_busy;
   int m_owner;
   int m_cnt;
   int m_ptr;

   slot_arbiter #(
      .NREQ    (N),
      .SLOT_LEN(L),
      .IDW     (IDW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .done     (done),
      .grant    (grant),
      .grant_id (grant_id),
      .slot_cnt (slot_cnt),
      .slot_last(slot_last),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int find_from(input logic [N-1:0] r, input int start);
      for (int k = 0; k < int'(N); k++) begin
         if (r[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [VW-1:0] model_vec();
      logic [N-1:0] g;
      g = '0;
      if (m_busy != 0) g[m_owner] = 1'b1;
      return {g, IDW'(m_busy != 0 ? m_owner : 0), 3'(m_cnt),
              1'(m_busy != 0 && m_cnt == int'(L) - 1), 1'(m_busy)};
   endfunction

   // Drive one cycle of inputs, clock it, advance the model, then settle past the edge.
   task automatic tick(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
      int hit;
      req  = r;
      done = d;
      rst  = rs;
      @(posedge clk);
      if (rs) begin
         m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      end else if (m_busy == 0) begin
         hit = find_from(r, m_ptr);
         if (hit >= 0) begin
            m_busy = 1; m_owner = hit; m_cnt = 0;
         end
      end else if (m_cnt == int'(L) - 1 || d[m_owner] || !r[m_owner]) begin
         m_ptr = (m_owner + 1) % N;
         hit   = find_from(r, m_ptr);
         if (hit >= 0) begin
            m_owner = hit; m_cnt = 0;
         end else begin
            m_busy = 0; m_owner = 0; m_cnt = 0;
         end
      end else begin
         m_cnt = m_cnt + 1;
      end
      #1;
   endtask

   task automatic test_reset();
      tick('0, '0, 1'b1);
      tick('0, '0, 1'b1);
      checks++;
      if ({grant, grant_id, slot_cnt, slot_last, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b exp 0", {grant, grant_id, slot_cnt, slot_last, busy});
      end
   endtask

   task automatic test_solo();
      test_reset();
      tick(4'b0001, '0, 1'b0);
      for (int i = 0; i < int'(L); i++) begin
         checks++;
         if (grant !== 4'b0001 || slot_cnt !== 3'(i) || slot_last !== (i == int'(L) - 1) || busy !== 1'b1) begin
            errors++;
            $display("FAIL solo_slot i=%0d got grant=%b cnt=%0d last=%b busy=%b exp grant=0001 cnt=%0d last=%b busy=1",
                     i, grant, slot_cnt, slot_last, busy, i, i == int'(L) - 1);
         end
         tick(4'b0001, '0, 1'b0);
      end
      checks++;
      if (grant !== 4'b0001 || slot_cnt !== 3'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL solo_regrant got grant=%b cnt=%0d busy=%b exp grant=0001 cnt=0 busy=1", grant, slot_cnt, busy);
      end
   endtask

   task automatic test_rotation();
      logic [N-1:0] exp_g;
      test_reset();
      tick(4'b1111, '0, 1'b0);
      for (int s = 0; s < 5; s++) begin
         exp_g = '0;
         exp_g[s % N] = 1'b1;
         for (int c = 0; c < int'(L); c++) begin
            checks++;
            if (grant !== exp_g || slot_cnt !== 3'(c) || grant_id !== IDW'(s % N) || busy !== 1'b1) begin
               errors++;
               $display("FAIL rotation s=%0d c=%0d got grant=%b id=%0d cnt=%0d busy=%b exp grant=%b id=%0d cnt=%0d busy=1",
                        s, c, grant, grant_id, slot_cnt, busy, exp_g, s % N, c);
            end
            tick(4'b1111, '0, 1'b0);
         end
      end
   endtask

   task automatic test_early_release();
      test_reset();
      tick(4'b0011, '0, 1'b0);
      tick(4'b0011, 4'b0010, 1'b0);
      checks++;
      if (grant !== 4'b0001 || slot_cnt !== 3'd1) begin
         errors++;
         $display("FAIL foreign_done got grant=%b cnt=%0d exp grant=0001 cnt=1", grant, slot_cnt);
      end
      tick(4'b0011, 4'b0001, 1'b0);
      checks++;
      if (grant !== 4'b0010 || slot_cnt !== 3'd0 || grant_id !== 2'd1) begin
         errors++;
         $display("FAIL early_release got grant=%b id=%0d cnt=%0d exp grant=0010 id=1 cnt=0", grant, grant_id, slot_cnt);
      end
   endtask

   task automatic test_req_drop();
      test_reset();
      tick(4'b0100, '0, 1'b0);
      tick(4'b0100, '0, 1'b0);
      tick(4'b0100, '0, 1'b0);
      checks++;
      if (grant !== 4'b0100 || slot_cnt !== 3'd2) begin
         errors++;
         $display("FAIL drop_setup got grant=%b cnt=%0d exp grant=0100 cnt=2", grant, slot_cnt);
      end
      tick('0, '0, 1'b0);
      checks++;
      if (busy !== 1'b0 || grant !== '0 || slot_cnt !== 3'd0 || grant_id !== '0) begin
         errors++;
         $display("FAIL req_drop got busy=%b grant=%b cnt=%0d id=%0d exp all 0", busy, grant, slot_cnt, grant_id);
      end
   endtask

   task automatic test_coincident();
      test_reset();
      tick(4'b0101, '0, 1'b0);
      for (int i = 0; i < 4; i++) tick(4'b0101, '0, 1'b0);
      checks++;
      if (grant !== 4'b0001 || slot_last !== 1'b1) begin
         errors++;
         $display("FAIL coinc_setup got grant=%b last=%b exp grant=0001 last=1", grant, slot_last);
      end
      tick(4'b0101, 4'b0001, 1'b0);
      checks++;
      if (grant !== 4'b0100 || slot_cnt !== 3'd0) begin
         errors++;
         $display("FAIL coinc_handover got grant=%b cnt=%0d exp grant=0100 cnt=0", grant, slot_cnt);
      end
      tick(4'b0101, '0, 1'b0);
      checks++;
      if (grant !== 4'b0100 || slot_cnt !== 3'd1) begin
         errors++;
         $display("FAIL coinc_single got grant=%b cnt=%0d exp grant=0100 cnt=1", grant, slot_cnt);
      end
      tick('0, '0, 1'b0);
      tick(4'b1111, '0, 1'b0);
      checks++;
      if (grant !== 4'b1000) begin
         errors++;
         $display("FAIL coinc_ptr got grant=%b exp 1000", grant);
      end
   endtask

   task automatic test_mid_reset();
      test_reset();
      tick(4'b1111, '0, 1'b0);
      for (int i = 0; i < int'(L) + 3; i++) tick(4'b1111, '0, 1'b0);
      checks++;
      if (grant !== 4'b0010 || slot_cnt !== 3'd3) begin
         errors++;
         $display("FAIL midrst_setup got grant=%b cnt=%0d exp grant=0010 cnt=3", grant, slot_cnt);
      end
      tick(4'b1111, '0, 1'b1);
      checks++;
      if ({grant, grant_id, slot_cnt, slot_last, busy} !== '0) begin
         errors++;
         $display("FAIL midrst_outputs got %b exp 0", {grant, grant_id, slot_cnt, slot_last, busy});
      end
      tick(4'b1111, '0, 1'b0);
      checks++;
      if (grant !== 4'b0001 || slot_cnt !== 3'd0) begin
         errors++;
         $display("FAIL midrst_first got grant=%b cnt=%0d exp grant=0001 cnt=0", grant, slot_cnt);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic [N-1:0] d;
      logic         rs;
      test_reset();
      r = '0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) r = N'($urandom);
         d  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         rs = ($urandom_range(0, 63) == 0);
         tick(r, d, rs);
         checks++;
         if ({grant, grant_id, slot_cnt, slot_last, busy} !== model_vec()) begin
            errors++;
            $display("FAIL random cyc=%0d got grant=%b id=%0d cnt=%0d last=%b busy=%b exp vec=%b",
                     i, grant, grant_id, slot_cnt, slot_last, busy, model_vec());
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      rst    = 1'b1;
      req    = '0;
      done   = '0;
      test_reset();
      test_solo();
      test_rotation();
      test_early_release();
      test_req_drop();
      test_coincident();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
